hbridge_pwm_driver: RTL and testbench
=====================================

HBRIDGE_PWM_DRIVER -- requirements
Module: hbridge_pwm_driver

Interface
REQ-001 The block SHALL have a parameter PWM_DIV, default 1250, giving the clocks per PWM slot (8 slots per period, 5 kHz at 50 MHz).
REQ-002 The block SHALL have a parameter DEAD_TIME, default 50000, giving the clocks of coast inserted before any motor reversal.
REQ-003 The block SHALL have a parameter RAMP_DIV, default 500000, giving the clocks per duty increment.
REQ-004 The block SHALL have a parameter TURN_INNER, default 3'd2, giving the inner-wheel duty during turns.
REQ-005 The block SHALL have port clock, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port sendToH_Bridge_INs, input, 4 bits: requested bridge inputs; motor A = [3:2], motor B = [1:0].
REQ-008 The block SHALL have port movDirec_isTurning_leftRight, input, 4 bits: motion code {moving, forward, turning, right}.
REQ-009 The block SHALL have port IN_out, output, 4 bits: applied bridge inputs to pins.
REQ-010 The block SHALL have ports ENA and ENB, outputs, 1 bit each: PWM enables for motors A and B.
REQ-011 The block SHALL have port previousH_Bridge_INs, output, 4 bits: applied INs, fed back to the decision block.
REQ-012 The block SHALL have port previousSpeeds, output, 6 bits: {dutyA[2:0], dutyB[2:0]} currently applied.
REQ-013 The block SHALL have port previous_movDirec_isTurning_leftRight_fromHBridge, output, 4 bits: last accepted motion code.

Function
REQ-014 The block SHALL register both inputs every clock; all decisions SHALL use the registered copies (1-cycle input latency).
REQ-015 Target duties (A,B) SHALL be: 1100/1000 -> (7,7); 1111/1010 -> (7,TURN_INNER); 1110/1011 -> (TURN_INNER,7); 1001 -> hold previous targets; bit3=0 or any other code -> (0,0).
REQ-016 The block SHALL implement a state machine with states RUN, DEAD and BRAKE.
REQ-017 In RUN, a request of 1111 SHALL cause: IN_out=1111, ENA=ENB=1 constant, duties forced to 0, state -> BRAKE, next cycle.
REQ-018 In RUN, a reversal (either motor's applied pair is 10 and the request is 01, or vice versa) SHALL cause: IN_out=0000, ENA=ENB=0, duties=0, dead counter loaded with DEAD_TIME-1, state -> DEAD.
REQ-019 In RUN, any other request SHALL be applied to IN_out on the next cycle.
REQ-020 In DEAD, the counter SHALL decrement each clock; at 0 the current request SHALL be applied and the state SHALL return to RUN; requests during DEAD SHALL not restart the counter.
REQ-021 In BRAKE, the state SHALL hold while the request is 1111; any other request SHALL enter DEAD (IN_out=0000).
REQ-022 Duty ramp in RUN: when a duty is below its target, it SHALL increment by 1 on each RAMP_DIV tick; when above, it SHALL drop to the target immediately.
REQ-023 Duty SHALL stay within 0..7 with no wrap.
REQ-024 The PWM SHALL use a 3-bit slot counter advancing every PWM_DIV clocks and wrapping 7->0.
REQ-025 In RUN, ENx = (slot < dutyx); duty 0 -> always low, duty 7 -> 7/8 high.
REQ-026 Simultaneous events: 1111 SHALL beat reversal, which SHALL beat the ramp tick; a ramp tick in DEAD/BRAKE SHALL be ignored.
REQ-027 previousH_Bridge_INs SHALL equal IN_out, and previousSpeeds SHALL equal the current duties, same cycle.
REQ-028 The motion code SHALL be latched every cycle except when it is 1001.

Reset
REQ-029 On reset assertion, asynchronously: state=RUN; IN_out, ENA, ENB, duties, targets, counters, slot, and all feedback outputs = 0.
REQ-030 Reset mid-DEAD or mid-BRAKE SHALL abort the operation; after release the block SHALL take the first request with no residual dead time.

Verification (PWM_DIV=2, DEAD_TIME=10, RAMP_DIV=4)
REQ-031 Reset, then INs=1001, code=1100 -> IN_out=1001 after 2 clocks; duties step 0..7, one step per 4 clocks; previousSpeeds reaches 6'o77.
REQ-032 Running 1001 at duty 7, then request 0110 -> IN_out=0000, ENA=ENB=0 for 10 clocks, then 0110, with the ramp restarting from 0.
REQ-033 Request 1111 while ramping -> IN_out=1111 and ENA=ENB=1 next cycle; then 1001 -> 10 clocks of 0000, then 1001.
REQ-034 Code 1111 at duty (7,7) -> dutyB drops to 2 in 1 cycle; ENB is high for 2 of 8 slots.
REQ-035 Reset asserted at DEAD count 5 -> all outputs 0 immediately; after release, 1001 is applied within 2 clocks.
REQ-036 Code 1001 after 1110 -> targets stay (2,7); the feedback code stays 1110.

Source files
------------

// File: rtl/hbridge_pwm_driver.sv
// H-bridge driver: applies requested bridge inputs with dead-time on reversal, brake handling and ramped PWM duty.
// Latency: inputs registered (1 clk), outputs registered (1 clk) -> request visible on IN_out 2 clocks after it is driven.
// Backpressure: none; the request is sampled every clock and reversals are deferred internally by the dead-time coast.
module hbridge_pwm_driver #(
  parameter int         PWM_DIV    = 1250,
  parameter int         DEAD_TIME  = 50000,
  parameter int         RAMP_DIV   = 500000,
  parameter logic [2:0] TURN_INNER = 3'd2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] sendToH_Bridge_INs,
  input  logic [3:0] movDirec_isTurning_leftRight,
  output logic [3:0] IN_out,
  output logic       ENA,
  output logic       ENB,
  output logic [3:0] previousH_Bridge_INs,
  output logic [5:0] previousSpeeds,
  output logic [3:0] previous_movDirec_isTurning_leftRight_fromHBridge
);

  localparam int PW = $clog2(PWM_DIV + 1);
  localparam int DW = $clog2(DEAD_TIME + 1);
  localparam int RW = $clog2(RAMP_DIV + 1);

  typedef enum logic [1:0] {RUN = 2'd0, DEAD = 2'd1, BRAKE = 2'd2} state_t;

  state_t          state_q;
  logic [3:0]      req_q;
  logic [3:0]      code_q;
  logic [3:0]      code_fb_q;
  logic [3:0]      in_q;
  logic            ena_q;
  logic            enb_q;
  logic [2:0]      duty_a_q;
  logic [2:0]      duty_b_q;
  logic [2:0]      tgt_a_q;
  logic [2:0]      tgt_b_q;
  logic [2:0]      tgt_a_d;
  logic [2:0]      tgt_b_d;
  logic [DW-1:0]   dead_cnt_q;
  logic [PW-1:0]   pwm_div_q;
  logic [2:0]      slot_q;
  logic [RW-1:0]   ramp_cnt_q;
  logic            ramp_tick;
  logic            slot_tick;
  logic            reversal;

  // A motor pair flips direction when it goes 10 -> 01 or 01 -> 10.
  function automatic logic pair_rev(input logic [1:0] cur, input logic [1:0] req);
    return ((cur == 2'b10) && (req == 2'b01)) || ((cur == 2'b01) && (req == 2'b10));
  endfunction

  // Ramp up one step per tick, but never lag behind a lowered target.
  function automatic logic [2:0] ramp_step(input logic [2:0] duty, input logic [2:0] tgt,
                                           input logic tick);
    if (duty > tgt)              return tgt;
    else if ((duty < tgt) && tick) return duty + 3'd1;
    else                         return duty;
  endfunction

  assign ramp_tick = (ramp_cnt_q == RW'(RAMP_DIV - 1));
  assign slot_tick = (pwm_div_q == PW'(PWM_DIV - 1));
  assign reversal  = pair_rev(in_q[3:2], req_q[3:2]) | pair_rev(in_q[1:0], req_q[1:0]);

  // Decode the registered motion code into per-wheel target duties; 1001 keeps the old targets.
  always_comb begin
    tgt_a_d = 3'd0;
    tgt_b_d = 3'd0;
    case (code_q)
      4'b1100, 4'b1000: begin tgt_a_d = 3'd7;       tgt_b_d = 3'd7;       end
      4'b1111, 4'b1010: begin tgt_a_d = 3'd7;       tgt_b_d = TURN_INNER; end
      4'b1110, 4'b1011: begin tgt_a_d = TURN_INNER; tgt_b_d = 3'd7;       end
      4'b1001:          begin tgt_a_d = tgt_a_q;    tgt_b_d = tgt_b_q;    end
      default:          begin tgt_a_d = 3'd0;       tgt_b_d = 3'd0;       end
    endcase
  end

  // Register the raw inputs, the held targets and the accepted motion code.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_q     <= 4'd0;
      code_q    <= 4'd0;
      code_fb_q <= 4'd0;
      tgt_a_q   <= 3'd0;
      tgt_b_q   <= 3'd0;
    end else begin
      req_q   <= sendToH_Bridge_INs;
      code_q  <= movDirec_isTurning_leftRight;
      tgt_a_q <= tgt_a_d;
      tgt_b_q <= tgt_b_d;
      if (code_q != 4'b1001) code_fb_q <= code_q;
    end
  end

  // Free-running PWM slot prescaler/slot counter and ramp tick divider.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_div_q  <= '0;
      slot_q     <= 3'd0;
      ramp_cnt_q <= '0;
    end else begin
      if (slot_tick) begin
        pwm_div_q <= '0;
        slot_q    <= slot_q + 3'd1;
      end else begin
        pwm_div_q <= pwm_div_q + PW'(1);
      end
      if (ramp_tick) ramp_cnt_q <= '0;
      else           ramp_cnt_q <= ramp_cnt_q + RW'(1);
    end
  end

  // Bridge state machine: run/ramp, dead-time coast before reversal, and brake hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      in_q       <= 4'd0;
      ena_q      <= 1'b0;
      enb_q      <= 1'b0;
      duty_a_q   <= 3'd0;
      duty_b_q   <= 3'd0;
      dead_cnt_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (req_q == 4'b1111) begin
            in_q     <= 4'b1111;
            ena_q    <= 1'b1;
            enb_q    <= 1'b1;
            duty_a_q <= 3'd0;
            duty_b_q <= 3'd0;
            state_q  <= BRAKE;
          end else if (reversal) begin
            in_q       <= 4'd0;
            ena_q      <= 1'b0;
            enb_q      <= 1'b0;
            duty_a_q   <= 3'd0;
            duty_b_q   <= 3'd0;
            dead_cnt_q <= DW'(DEAD_TIME - 1);
            state_q    <= DEAD;
          end else begin
            in_q     <= req_q;
            duty_a_q <= ramp_step(duty_a_q, tgt_a_d, ramp_tick);
            duty_b_q <= ramp_step(duty_b_q, tgt_b_d, ramp_tick);
            ena_q    <= (slot_q < duty_a_q);
            enb_q    <= (slot_q < duty_b_q);
          end
        end
        DEAD: begin
          ena_q    <= 1'b0;
          enb_q    <= 1'b0;
          duty_a_q <= 3'd0;
          duty_b_q <= 3'd0;
          if (dead_cnt_q == '0) begin
            in_q    <= req_q;
            state_q <= RUN;
          end else begin
            in_q       <= 4'd0;
            dead_cnt_q <= dead_cnt_q - DW'(1);
          end
        end
        BRAKE: begin
          duty_a_q <= 3'd0;
          duty_b_q <= 3'd0;
          if (req_q == 4'b1111) begin
            in_q  <= 4'b1111;
            ena_q <= 1'b1;
            enb_q <= 1'b1;
          end else begin
            in_q       <= 4'd0;
            ena_q      <= 1'b0;
            enb_q      <= 1'b0;
            dead_cnt_q <= DW'(DEAD_TIME - 1);
            state_q    <= DEAD;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign IN_out               = in_q;
  assign ENA                  = ena_q;
  assign ENB                  = enb_q;
  assign previousH_Bridge_INs = in_q;
  assign previousSpeeds       = {duty_a_q, duty_b_q};
  assign previous_movDirec_isTurning_leftRight_fromHBridge = code_fb_q;

endmodule

// File: tb/tb_hbridge_pwm_driver.sv
// Directed bench for hbridge_pwm_driver with a cycle-stamped expectation scoreboard.
// Stimulus pushes expected values tagged with the cycle they must appear in.
// A negedge monitor pops and compares each entry when its cycle arrives.
module tb_hbridge_pwm_driver;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] ins;
  logic [3:0] code;
  logic [3:0] IN_out;
  logic       ENA;
  logic       ENB;
  logic [3:0] prev_ins;
  logic [5:0] prev_speeds;
  logic [3:0] prev_code;

  hbridge_pwm_driver #(
    .PWM_DIV(2), .DEAD_TIME(10), .RAMP_DIV(4), .TURN_INNER(3'd2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .sendToH_Bridge_INs(ins),
    .movDirec_isTurning_leftRight(code),
    .IN_out(IN_out),
    .ENA(ENA),
    .ENB(ENB),
    .previousH_Bridge_INs(prev_ins),
    .previousSpeeds(prev_speeds),
    .previous_movDirec_isTurning_leftRight_fromHBridge(prev_code)
  );

  always #5 clock = ~clock;

  // Cycle index: counts rising edges seen while out of reset.
  int cyc = 0;
  always @(posedge clock) if (!reset) cyc <= cyc + 1;

  typedef struct {
    int when;
    int sel;
    int val;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [15:0] ena_hist = '0;
  logic [15:0] enb_hist = '0;

  function automatic string sel_name(input int s);
    case (s)
      0: return "IN_out";
      1: return "previousSpeeds";
      2: return "ENA";
      3: return "ENB";
      4: return "prev_code";
      5: return "previousH_Bridge_INs";
      6: return "ENA_high_in_16";
      7: return "ENB_high_in_16";
      default: return "unknown";
    endcase
  endfunction

  function automatic int sample(input int s);
    case (s)
      0: return int'(IN_out);
      1: return int'(prev_speeds);
      2: return int'(ENA);
      3: return int'(ENB);
      4: return int'(prev_code);
      5: return int'(prev_ins);
      6: return $countones(ena_hist);
      7: return $countones(enb_hist);
      default: return -1;
    endcase
  endfunction

  task automatic push(input int when, input int sel, input int val);
    exp_t e;
    int pos;
    e.when = when;
    e.sel  = sel;
    e.val  = val;
    pos = sb.size();
    while (pos > 0 && sb[pos-1].when > when) pos--;
    sb.insert(pos, e);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Monitor: sample away from the rising edge and retire every expectation due this cycle.
  always @(negedge clock) begin
    exp_t e;
    int   got;
    ena_hist = {ena_hist[14:0], ENA};
    enb_hist = {enb_hist[14:0], ENB};
    while (sb.size() > 0 && sb[0].when <= cyc) begin
      e = sb.pop_front();
      n_checks++;
      if (e.when < cyc) begin
        $display("FAIL %s: due at cycle %0d but not sampled until %0d (required %0d)",
                 sel_name(e.sel), e.when, cyc, e.val);
      end else begin
        got = sample(e.sel);
        if (got == e.val) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, required 0x%0h",
                      sel_name(e.sel), cyc, got, e.val);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ins   = 4'd0;
    code  = 4'd0;
    for (int s = 0; s < 6; s++) push(0, s, 0);
    #22 reset = 1'b0;

    // Forward at full speed: 2-clock apply latency, ramp one step per 4 clocks.
    wait_cyc(1);
    ins = 4'b1001; code = 4'b1100;
    push(2, 0, 0);
    push(3, 0, 'h9); push(3, 5, 'h9); push(3, 4, 'hc); push(3, 1, 0);
    push(4, 1, 'o11); push(8, 1, 'o22); push(27, 1, 'o66); push(28, 1, 'o77);
    push(44, 6, 14); push(44, 7, 14);

    // Reversal: ten clocks of coast, then new direction with ramp from zero.
    wait_cyc(45);
    ins = 4'b0110;
    push(46, 0, 'h9);
    push(47, 0, 0); push(47, 1, 0); push(47, 2, 0);
    push(52, 2, 0); push(52, 3, 0);
    push(56, 0, 0); push(57, 0, 'h6);
    push(59, 1, 0); push(60, 1, 'o11);

    // Brake while ramping, then release into dead time.
    wait_cyc(65);
    ins = 4'b1111;
    push(66, 0, 'h6);
    push(67, 0, 'hf); push(67, 2, 1); push(67, 3, 1); push(67, 1, 0);
    push(71, 0, 'hf); push(71, 3, 1);
    wait_cyc(70);
    ins = 4'b1001;
    push(72, 0, 0); push(72, 2, 0);
    push(81, 0, 0); push(82, 0, 'h9);
    push(84, 1, 'o11); push(108, 1, 'o77);

    // Right turn at full speed: inner wheel drops at once, PWM 2 of 8 slots.
    wait_cyc(110);
    code = 4'b1111;
    push(111, 1, 'o77); push(112, 1, 'o72); push(112, 4, 'hf);
    push(130, 7, 4); push(130, 6, 14);

    // Left turn, then hold code 1001: targets and feedback code stay put.
    wait_cyc(131);
    code = 4'b1110;
    push(132, 1, 'o72); push(133, 1, 'o22); push(133, 4, 'he); push(136, 1, 'o23);
    wait_cyc(135);
    code = 4'b1001;
    push(140, 4, 'he); push(140, 1, 'o24);
    push(152, 1, 'o27); push(160, 1, 'o27); push(160, 4, 'he);

    // Reset in the middle of a dead-time coast.
    wait_cyc(161);
    ins = 4'b0110;
    push(162, 0, 'h9); push(163, 0, 0); push(163, 1, 0);
    wait_cyc(167);
    reset = 1'b1; ins = 4'b1001; code = 4'b1100;
    for (int s = 0; s < 6; s++) push(167, s, 0);
    @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    push(168, 0, 0); push(169, 0, 'h9); push(169, 4, 'hc);
    push(170, 1, 0); push(171, 1, 'o11);

    for (int i = 0; i < 40 && sb.size() > 0; i++) @(posedge clock);
    @(negedge clock);
    while (sb.size() > 0) begin
      n_checks++;
      $display("FAIL %s: expectation for cycle %0d never retired (required %0d)",
               sel_name(sb[0].sel), sb[0].when, sb[0].val);
      void'(sb.pop_front());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
